// File: rtl/monedero.sv
// Coin-slot front end for a washing machine: debounces coins, accumulates credit,
// hands the payment to the machine controller and refunds whatever it cannot accept.
module monedero #(
    parameter int DEBOUNCE    = 4,
    parameter int MAX_CREDITO = 15,
    parameter int TIMEOUT     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SENSOR_MONEDA,
    input  logic       BOTON_PAGO,
    input  logic       INSUFICIENTE,
    input  logic       VERIFICACION,
    input  logic       LAVADO,
    input  logic       LAVADO_PESADO,
    input  logic       SECADO,
    output logic       INTRO_MONEDA,
    output logic       FINALIZAR_PAGO,
    output logic       DEVOLVER,
    output logic [3:0] CREDITO,
    output logic       BLOQUEO
);

    // state      | meaning
    // IDLE       | no credit, slot open
    // ACUMULANDO | credit > 0, slot open, waiting for the pay button
    // ESPERA     | payment closed, waiting for the controller (slot locked)
    // OCUPADO    | machine running (slot locked)
    typedef enum logic [1:0] {IDLE, ACUMULANDO, ESPERA, OCUPADO} state_t;

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [3:0]    MAXC     = 4'(MAX_CREDITO);

    state_t        state_q;
    logic [3:0]    credito_q;
    logic          intro_q, fin_q, dev_q, bloq_q;
    logic          pend_q, act_q, btn_prev_q;
    logic [TW-1:0] tmr_q;
    logic [DW-1:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
    logic          armed_q, armed_d;
    logic          coin_qual, btn_edge;

    // Once a coin qualifies, the qualifier is disarmed until a full low run is seen.
    always_comb begin
        hi_cnt_d  = '0;
        lo_cnt_d  = '0;
        armed_d   = armed_q;
        coin_qual = 1'b0;
        if (SENSOR_MONEDA) begin
            if (armed_q) begin
                if (hi_cnt_q == DEB_LAST) begin
                    coin_qual = 1'b1;
                    armed_d   = 1'b0;
                end else begin
                    hi_cnt_d = hi_cnt_q + 1'b1;
                end
            end
        end else if (!armed_q) begin
            if (lo_cnt_q == DEB_LAST) armed_d = 1'b1;
            else                      lo_cnt_d = lo_cnt_q + 1'b1;
        end
    end

    assign btn_edge = BOTON_PAGO & ~btn_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            credito_q  <= '0;
            intro_q    <= 1'b0;
            fin_q      <= 1'b0;
            dev_q      <= 1'b0;
            bloq_q     <= 1'b0;
            pend_q     <= 1'b0;
            act_q      <= 1'b0;
            tmr_q      <= '0;
            hi_cnt_q   <= '0;
            lo_cnt_q   <= '0;
            armed_q    <= 1'b1;
            // Tracking the button through reset keeps a held button from looking like a press.
            btn_prev_q <= BOTON_PAGO;
        end else begin
            intro_q    <= 1'b0;
            fin_q      <= 1'b0;
            dev_q      <= 1'b0;
            btn_prev_q <= BOTON_PAGO;
            hi_cnt_q   <= hi_cnt_d;
            lo_cnt_q   <= lo_cnt_d;
            armed_q    <= armed_d;
            case (state_q)
                IDLE, ACUMULANDO: begin
                    if (pend_q) begin
                        pend_q  <= 1'b0;
                        fin_q   <= 1'b1;
                        tmr_q   <= '0;
                        bloq_q  <= 1'b1;
                        state_q <= ESPERA;
                        if (coin_qual) dev_q <= 1'b1;
                    end else if (coin_qual && credito_q < MAXC) begin
                        credito_q <= credito_q + 1'b1;
                        intro_q   <= 1'b1;
                        state_q   <= ACUMULANDO;
                        // Defer the close so INTRO_MONEDA and FINALIZAR_PAGO never overlap.
                        pend_q    <= btn_edge;
                    end else begin
                        if (coin_qual) dev_q <= 1'b1;
                        if (btn_edge && state_q == ACUMULANDO) begin
                            fin_q   <= 1'b1;
                            tmr_q   <= '0;
                            bloq_q  <= 1'b1;
                            state_q <= ESPERA;
                        end
                    end
                end
                ESPERA: begin
                    if (coin_qual) dev_q <= 1'b1;
                    if (INSUFICIENTE) begin
                        dev_q     <= 1'b1;
                        credito_q <= '0;
                        bloq_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (VERIFICACION) begin
                        credito_q <= '0;
                        act_q     <= 1'b0;
                        state_q   <= OCUPADO;
                    end else if (tmr_q == TO_LAST) begin
                        dev_q     <= 1'b1;
                        credito_q <= '0;
                        bloq_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                OCUPADO: begin
                    if (coin_qual) dev_q <= 1'b1;
                    if (LAVADO || LAVADO_PESADO || SECADO) begin
                        act_q <= 1'b1;
                    end else if (act_q) begin
                        act_q   <= 1'b0;
                        bloq_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    bloq_q  <= 1'b0;
                end
            endcase
        end
    end

    assign INTRO_MONEDA   = intro_q;
    assign FINALIZAR_PAGO = fin_q;
    assign DEVOLVER       = dev_q;
    assign CREDITO        = credito_q;
    assign BLOQUEO        = bloq_q;

endmodule

// File: tb/tb_monedero.sv
// Directed bench for monedero: coins, payment accept/refund/timeout, saturation and reset.
module tb_monedero;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       SENSOR_MONEDA = 1'b0;
    logic       BOTON_PAGO = 1'b0;
    logic       INSUFICIENTE = 1'b0;
    logic       VERIFICACION = 1'b0;
    logic       LAVADO = 1'b0;
    logic       LAVADO_PESADO = 1'b0;
    logic       SECADO = 1'b0;
    logic       INTRO_MONEDA, FINALIZAR_PAGO, DEVOLVER, BLOQUEO;
    logic [3:0] CREDITO;

    int checks = 0;
    int errors = 0;
    int n_intro = 0;
    int n_fin = 0;
    int n_dev = 0;
    int n_both = 0;

    monedero #(.DEBOUNCE(4), .MAX_CREDITO(15), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .SENSOR_MONEDA(SENSOR_MONEDA), .BOTON_PAGO(BOTON_PAGO),
        .INSUFICIENTE(INSUFICIENTE), .VERIFICACION(VERIFICACION),
        .LAVADO(LAVADO), .LAVADO_PESADO(LAVADO_PESADO), .SECADO(SECADO),
        .INTRO_MONEDA(INTRO_MONEDA), .FINALIZAR_PAGO(FINALIZAR_PAGO),
        .DEVOLVER(DEVOLVER), .CREDITO(CREDITO), .BLOQUEO(BLOQUEO)
    );

    always #5 clk = ~clk;

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (INTRO_MONEDA === 1'b1) n_intro++;
        if (FINALIZAR_PAGO === 1'b1) n_fin++;
        if (DEVOLVER === 1'b1) n_dev++;
        if (INTRO_MONEDA === 1'b1 && FINALIZAR_PAGO === 1'b1) n_both++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input int hi, input int lo);
        SENSOR_MONEDA = 1'b1;
        repeat (hi) tick();
        SENSOR_MONEDA = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic clear_counts();
        n_intro = 0;
        n_fin = 0;
        n_dev = 0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_intro", 32'(INTRO_MONEDA), 0);
        chk("rst_fin", 32'(FINALIZAR_PAGO), 0);
        chk("rst_dev", 32'(DEVOLVER), 0);
        chk("rst_credito", 32'(CREDITO), 0);
        chk("rst_bloqueo", 32'(BLOQUEO), 0);
        clear_counts();

        // First coin with exact pulse timing
        SENSOR_MONEDA = 1'b1;
        repeat (3) tick();
        chk("coin1_no_early_intro", 32'(INTRO_MONEDA), 0);
        tick();
        chk("coin1_intro", 32'(INTRO_MONEDA), 1);
        chk("coin1_credito", 32'(CREDITO), 1);
        SENSOR_MONEDA = 1'b0;
        tick();
        chk("coin1_intro_one_cycle", 32'(INTRO_MONEDA), 0);
        repeat (3) tick();
        coin(4, 4);
        coin(4, 4);
        chk("three_coins_pulses", 32'(n_intro), 3);
        chk("three_coins_credito", 32'(CREDITO), 3);

        // 3-cycle glitch, then a short low that must not re-arm
        coin(3, 4);
        chk("glitch_no_pulse", 32'(n_intro), 3);
        coin(4, 2);
        coin(4, 4);
        chk("rearm_pulses", 32'(n_intro), 4);
        chk("rearm_credito", 32'(CREDITO), 4);

        // Reset mid-payment: credit lost, no refund
        clear_counts();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_credito", 32'(CREDITO), 0);
        chk("rst_mid_no_dev", 32'(n_dev), 0);

        // Accepted payment, washing cycle, release
        coin(4, 4);
        coin(4, 4);
        chk("pay_credito2", 32'(CREDITO), 2);
        clear_counts();
        BOTON_PAGO = 1'b1;
        tick();
        chk("pay_fin", 32'(FINALIZAR_PAGO), 1);
        chk("pay_bloqueo", 32'(BLOQUEO), 1);
        tick();
        tick();
        VERIFICACION = 1'b1;
        tick();
        VERIFICACION = 1'b0;
        chk("pay_ok_credito", 32'(CREDITO), 0);
        chk("pay_ok_bloqueo", 32'(BLOQUEO), 1);
        chk("pay_single_fin", 32'(n_fin), 1);
        BOTON_PAGO = 1'b0;
        LAVADO = 1'b1;
        repeat (10) tick();
        chk("wash_locked", 32'(BLOQUEO), 1);
        LAVADO = 1'b0;
        tick();
        chk("wash_done_unlock", 32'(BLOQUEO), 0);
        chk("pay_ok_no_dev", 32'(n_dev), 0);

        // Timeout refund on the 8th ESPERA cycle
        coin(4, 4);
        clear_counts();
        BOTON_PAGO = 1'b1;
        tick();
        BOTON_PAGO = 1'b0;
        chk("to_fin", 32'(FINALIZAR_PAGO), 1);
        repeat (7) tick();
        chk("to_no_early_dev", 32'(n_dev), 0);
        tick();
        chk("to_dev", 32'(DEVOLVER), 1);
        chk("to_credito", 32'(CREDITO), 0);
        chk("to_bloqueo", 32'(BLOQUEO), 0);
        tick();
        chk("to_dev_one_cycle", 32'(DEVOLVER), 0);

        // Both responses together: refund wins
        coin(4, 4);
        BOTON_PAGO = 1'b1;
        tick();
        BOTON_PAGO = 1'b0;
        INSUFICIENTE = 1'b1;
        VERIFICACION = 1'b1;
        tick();
        INSUFICIENTE = 1'b0;
        VERIFICACION = 1'b0;
        chk("both_dev", 32'(DEVOLVER), 1);
        chk("both_credito", 32'(CREDITO), 0);
        chk("both_bloqueo", 32'(BLOQUEO), 0);
        tick();

        // Saturation at 15, then a coin while the machine runs
        clear_counts();
        repeat (15) coin(4, 4);
        chk("sat_pulses15", 32'(n_intro), 15);
        chk("sat_credito15", 32'(CREDITO), 15);
        coin(4, 4);
        chk("sat16_no_intro", 32'(n_intro), 15);
        chk("sat16_dev", 32'(n_dev), 1);
        chk("sat16_credito", 32'(CREDITO), 15);
        BOTON_PAGO = 1'b1;
        tick();
        BOTON_PAGO = 1'b0;
        VERIFICACION = 1'b1;
        tick();
        VERIFICACION = 1'b0;
        chk("run_credito", 32'(CREDITO), 0);
        coin(4, 4);
        chk("run_coin_dev", 32'(n_dev), 2);
        chk("run_coin_no_intro", 32'(n_intro), 15);
        chk("run_coin_credito", 32'(CREDITO), 0);
        repeat (20) tick();
        chk("run_no_activity_locked", 32'(BLOQUEO), 1);

        // Coin and button on the same edge
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_release_run", 32'(BLOQUEO), 0);
        SENSOR_MONEDA = 1'b1;
        repeat (3) tick();
        BOTON_PAGO = 1'b1;
        tick();
        chk("same_edge_intro", 32'(INTRO_MONEDA), 1);
        chk("same_edge_no_fin", 32'(FINALIZAR_PAGO), 0);
        tick();
        SENSOR_MONEDA = 1'b0;
        BOTON_PAGO = 1'b0;
        chk("same_edge_fin_next", 32'(FINALIZAR_PAGO), 1);
        chk("same_edge_intro_off", 32'(INTRO_MONEDA), 0);
        chk("same_edge_credito", 32'(CREDITO), 1);

        // Reset while in ESPERA
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_espera_intro", 32'(INTRO_MONEDA), 0);
        chk("rst_espera_fin", 32'(FINALIZAR_PAGO), 0);
        chk("rst_espera_dev", 32'(DEVOLVER), 0);
        chk("rst_espera_credito", 32'(CREDITO), 0);
        chk("rst_espera_bloqueo", 32'(BLOQUEO), 0);

        // Sensor high through reset needs a full run afterwards
        SENSOR_MONEDA = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_no_early_coin", 32'(INTRO_MONEDA), 0);
        tick();
        chk("post_rst_full_run_coin", 32'(INTRO_MONEDA), 1);
        SENSOR_MONEDA = 1'b0;
        repeat (4) tick();

        // Button held through reset gives no edge until pressed again
        BOTON_PAGO = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_counts();
        coin(4, 4);
        chk("held_btn_credito", 32'(CREDITO), 1);
        chk("held_btn_no_fin", 32'(n_fin), 0);
        BOTON_PAGO = 1'b0;
        tick();
        BOTON_PAGO = 1'b1;
        tick();
        chk("repress_fin", 32'(FINALIZAR_PAGO), 1);
        BOTON_PAGO = 1'b0;
        tick();

        chk("intro_fin_never_together", 32'(n_both), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
